// File: rtl/hdmi_pkg.sv
// Shared definitions for the packed video bus: default raster size,
// derived field widths and the bit offset of every field in the pack word.
package hdmi_pkg;

   localparam int H_ACT_DEF = 1280;
   localparam int V_ACT_DEF = 720;
   localparam int COLOR_W   = 8;

   function automatic int xw_f(input int h_act);
      return $clog2(h_act);
   endfunction

   function automatic int yw_f(input int v_act);
      return $clog2(v_act);
   endfunction

   function automatic int pack_size_f(input int h_act, input int v_act);
      return 3 * COLOR_W + 4 + xw_f(h_act) + yw_f(v_act);
   endfunction

   // Offsets run LSB upward: y, x, b, g, r, de, vsync, hsync, clk.
   function automatic int off_x_f(input int v_act);
      return yw_f(v_act);
   endfunction

   function automatic int off_b_f(input int h_act, input int v_act);
      return xw_f(h_act) + yw_f(v_act);
   endfunction

   function automatic int off_g_f(input int h_act, input int v_act);
      return off_b_f(h_act, v_act) + COLOR_W;
   endfunction

   function automatic int off_r_f(input int h_act, input int v_act);
      return off_g_f(h_act, v_act) + COLOR_W;
   endfunction

   function automatic int off_de_f(input int h_act, input int v_act);
      return off_r_f(h_act, v_act) + COLOR_W;
   endfunction

   function automatic int off_vs_f(input int h_act, input int v_act);
      return off_de_f(h_act, v_act) + 1;
   endfunction

   function automatic int off_hs_f(input int h_act, input int v_act);
      return off_de_f(h_act, v_act) + 2;
   endfunction

   function automatic int off_clk_f(input int h_act, input int v_act);
      return off_de_f(h_act, v_act) + 3;
   endfunction

endpackage

// File: rtl/hdmi_pack.sv
// Packs sync, colour and position into one bus word; the clock bit is
// always carried live, the rest optionally through one register stage.
module hdmi_pack
   import hdmi_pkg::*;
#(
   parameter int H_ACT   = H_ACT_DEF,
   parameter int V_ACT   = V_ACT_DEF,
   parameter bit OUT_REG = 1'b0,
   localparam int XW = xw_f(H_ACT),
   localparam int YW = yw_f(V_ACT),
   localparam int PW = pack_size_f(H_ACT, V_ACT)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          p_hsync,
   input  logic          p_vsync,
   input  logic          p_de,
   input  logic [7:0]    p_r,
   input  logic [7:0]    p_g,
   input  logic [7:0]    p_b,
   input  logic [XW-1:0] p_x,
   input  logic [YW-1:0] p_y,
   output logic [PW-1:0] o_pack
);

   localparam int DW     = PW - 1;
   localparam int OFF_X  = off_x_f(V_ACT);
   localparam int OFF_B  = off_b_f(H_ACT, V_ACT);
   localparam int OFF_G  = off_g_f(H_ACT, V_ACT);
   localparam int OFF_R  = off_r_f(H_ACT, V_ACT);
   localparam int OFF_DE = off_de_f(H_ACT, V_ACT);
   localparam int OFF_VS = off_vs_f(H_ACT, V_ACT);
   localparam int OFF_HS = off_hs_f(H_ACT, V_ACT);

   logic [DW-1:0] data_d;
   logic [DW-1:0] data_q;

   always_comb begin
      data_d                   = '0;
      data_d[0 +: YW]          = p_y;
      data_d[OFF_X +: XW]      = p_x;
      data_d[OFF_B +: COLOR_W] = p_b;
      data_d[OFF_G +: COLOR_W] = p_g;
      data_d[OFF_R +: COLOR_W] = p_r;
      data_d[OFF_DE]           = p_de;
      data_d[OFF_VS]           = p_vsync;
      data_d[OFF_HS]           = p_hsync;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   // The clock bit bypasses the register so consumers always see it live.
   assign o_pack = {clk, (OUT_REG ? data_q : data_d)};

endmodule

// File: rtl/hdmi_unpack.sv
// Splits a packed video bus word back into its fields; purely
// combinational, so it has no clock or reset of its own.
module hdmi_unpack
   import hdmi_pkg::*;
#(
   parameter int H_ACT = H_ACT_DEF,
   parameter int V_ACT = V_ACT_DEF,
   localparam int XW = xw_f(H_ACT),
   localparam int YW = yw_f(V_ACT),
   localparam int PW = pack_size_f(H_ACT, V_ACT)
) (
   input  logic [PW-1:0] i_pack,
   output logic          u_clk,
   output logic          u_hsync,
   output logic          u_vsync,
   output logic          u_de,
   output logic [7:0]    u_r,
   output logic [7:0]    u_g,
   output logic [7:0]    u_b,
   output logic [XW-1:0] u_x,
   output logic [YW-1:0] u_y
);

   localparam int OFF_X   = off_x_f(V_ACT);
   localparam int OFF_B   = off_b_f(H_ACT, V_ACT);
   localparam int OFF_G   = off_g_f(H_ACT, V_ACT);
   localparam int OFF_R   = off_r_f(H_ACT, V_ACT);
   localparam int OFF_DE  = off_de_f(H_ACT, V_ACT);
   localparam int OFF_VS  = off_vs_f(H_ACT, V_ACT);
   localparam int OFF_HS  = off_hs_f(H_ACT, V_ACT);
   localparam int OFF_CLK = off_clk_f(H_ACT, V_ACT);

   assign u_clk   = i_pack[OFF_CLK];
   assign u_hsync = i_pack[OFF_HS];
   assign u_vsync = i_pack[OFF_VS];
   assign u_de    = i_pack[OFF_DE];
   assign u_r     = i_pack[OFF_R +: COLOR_W];
   assign u_g     = i_pack[OFF_G +: COLOR_W];
   assign u_b     = i_pack[OFF_B +: COLOR_W];
   assign u_x     = i_pack[OFF_X +: XW];
   assign u_y     = i_pack[0 +: YW];

endmodule

// File: rtl/hdmi_pack_unpack.sv
// Thin wrapper pairing the bus packer with an independent unpacker.
// Downstream logic takes its clock from u_clk.
module hdmi_pack_unpack
   import hdmi_pkg::*;
#(
   parameter int H_ACT   = H_ACT_DEF,
   parameter int V_ACT   = V_ACT_DEF,
   parameter bit OUT_REG = 1'b0,
   localparam int XW = xw_f(H_ACT),
   localparam int YW = yw_f(V_ACT),
   localparam int PACK_SIZE = pack_size_f(H_ACT, V_ACT)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 p_hsync,
   input  logic                 p_vsync,
   input  logic                 p_de,
   input  logic [7:0]           p_r,
   input  logic [7:0]           p_g,
   input  logic [7:0]           p_b,
   input  logic [XW-1:0]        p_x,
   input  logic [YW-1:0]        p_y,
   output logic [PACK_SIZE-1:0] o_pack,
   input  logic [PACK_SIZE-1:0] i_pack,
   output logic                 u_clk,
   output logic                 u_hsync,
   output logic                 u_vsync,
   output logic                 u_de,
   output logic [7:0]           u_r,
   output logic [7:0]           u_g,
   output logic [7:0]           u_b,
   output logic [XW-1:0]        u_x,
   output logic [YW-1:0]        u_y
);

   hdmi_pack #(
      .H_ACT   (H_ACT),
      .V_ACT   (V_ACT),
      .OUT_REG (OUT_REG)
   ) u_pack (
      .clk     (clk),
      .rstn    (rstn),
      .p_hsync (p_hsync),
      .p_vsync (p_vsync),
      .p_de    (p_de),
      .p_r     (p_r),
      .p_g     (p_g),
      .p_b     (p_b),
      .p_x     (p_x),
      .p_y     (p_y),
      .o_pack  (o_pack)
   );

   hdmi_unpack #(
      .H_ACT (H_ACT),
      .V_ACT (V_ACT)
   ) u_unpack (
      .i_pack  (i_pack),
      .u_clk   (u_clk),
      .u_hsync (u_hsync),
      .u_vsync (u_vsync),
      .u_de    (u_de),
      .u_r     (u_r),
      .u_g     (u_g),
      .u_b     (u_b),
      .u_x     (u_x),
      .u_y     (u_y)
   );

endmodule

// File: tb/tb_hdmi_pack_unpack.sv
// Bench for hdmi_pack_unpack: one combinational and one registered
// instance share the pack-side inputs and are checked against a model.
module tb_hdmi_pack_unpack;

   localparam int XW = 11;
   localparam int YW = 10;
   localparam int PW = 49;

   typedef struct packed {
      logic          hs;
      logic          vs;
      logic          de;
      logic [7:0]    r;
      logic [7:0]    g;
      logic [7:0]    b;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
   } vid_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic loop = 1'b0;
   vid_t pv = '0;
   logic [PW-1:0] drv = '0;
   logic [PW-1:0] o0, o1, i0, i1;

   logic u0_clk, u0_hs, u0_vs, u0_de;
   logic u1_clk, u1_hs, u1_vs, u1_de;
   logic [7:0] u0_r, u0_g, u0_b, u1_r, u1_g, u1_b;
   logic [XW-1:0] u0_x, u1_x;
   logic [YW-1:0] u0_y, u1_y;
   vid_t u0, u1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign i0 = loop ? o0 : drv;
   assign i1 = loop ? o1 : drv;

   always_comb begin
      u0 = {u0_hs, u0_vs, u0_de, u0_r, u0_g, u0_b, u0_x, u0_y};
      u1 = {u1_hs, u1_vs, u1_de, u1_r, u1_g, u1_b, u1_x, u1_y};
   end

   hdmi_pack_unpack #(.H_ACT(1280), .V_ACT(720), .OUT_REG(1'b0)) dut0 (
      .clk(clk), .rstn(rstn),
      .p_hsync(pv.hs), .p_vsync(pv.vs), .p_de(pv.de),
      .p_r(pv.r), .p_g(pv.g), .p_b(pv.b), .p_x(pv.x), .p_y(pv.y),
      .o_pack(o0), .i_pack(i0),
      .u_clk(u0_clk), .u_hsync(u0_hs), .u_vsync(u0_vs), .u_de(u0_de),
      .u_r(u0_r), .u_g(u0_g), .u_b(u0_b), .u_x(u0_x), .u_y(u0_y)
   );

   hdmi_pack_unpack #(.H_ACT(1280), .V_ACT(720), .OUT_REG(1'b1)) dut1 (
      .clk(clk), .rstn(rstn),
      .p_hsync(pv.hs), .p_vsync(pv.vs), .p_de(pv.de),
      .p_r(pv.r), .p_g(pv.g), .p_b(pv.b), .p_x(pv.x), .p_y(pv.y),
      .o_pack(o1), .i_pack(i1),
      .u_clk(u1_clk), .u_hsync(u1_hs), .u_vsync(u1_vs), .u_de(u1_de),
      .u_r(u1_r), .u_g(u1_g), .u_b(u1_b), .u_x(u1_x), .u_y(u1_y)
   );

   // Reference pack word built from the field weights of the bus layout.
   function automatic logic [PW-1:0] exp_pack(input logic c, input vid_t v);
      logic [PW-1:0] e;
      e = PW'(v.y);
      e = e + (PW'(v.x) * (PW'(1) << 10));
      e = e + (PW'(v.b) * (PW'(1) << 21));
      e = e + (PW'(v.g) * (PW'(1) << 29));
      e = e + (PW'(v.r) * (PW'(1) << 37));
      e = e + (PW'(v.de) * (PW'(1) << 45));
      e = e + (PW'(v.vs) * (PW'(1) << 46));
      e = e + (PW'(v.hs) * (PW'(1) << 47));
      e = e + (PW'(c) * (PW'(1) << 48));
      return e;
   endfunction

   function automatic vid_t rand_vid();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return vid_t'(t[47:0]);
   endfunction

   task automatic test_reset();
      pv = '1;
      @(negedge clk);
      checks++;
      if (o1 !== {1'b0, 48'h0}) begin
         errors++;
         $display("FAIL reset_zero: got %h want %h", o1, {1'b0, 48'h0});
      end
      checks++;
      if (o0 !== exp_pack(1'b0, pv)) begin
         errors++;
         $display("FAIL reset_comb: got %h want %h", o0, exp_pack(1'b0, pv));
      end
      @(posedge clk);
      #1;
      checks++;
      if (o1 !== {1'b1, 48'h0}) begin
         errors++;
         $display("FAIL reset_clk_live: got %h want %h", o1, {1'b1, 48'h0});
      end
      @(negedge clk);
      #2 rstn = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (o1 !== exp_pack(1'b1, pv)) begin
         errors++;
         $display("FAIL reset_release: got %h want %h", o1, exp_pack(1'b1, pv));
      end
   endtask

   task automatic test_directed();
      logic [47:0] lit;
      lit = {3'b101, 8'hA5, 8'h3C, 8'h0F, 11'd1279, 10'd719};
      @(negedge clk);
      pv = '{hs: 1'b1, vs: 1'b0, de: 1'b1, r: 8'hA5, g: 8'h3C,
             b: 8'h0F, x: 11'd1279, y: 10'd719};
      #1;
      checks++;
      if (o0 !== {1'b0, lit}) begin
         errors++;
         $display("FAIL directed_lo: got %h want %h", o0, {1'b0, lit});
      end
      checks++;
      if (o0 !== exp_pack(1'b0, pv)) begin
         errors++;
         $display("FAIL directed_model: got %h want %h", o0, exp_pack(1'b0, pv));
      end
      @(posedge clk);
      #1;
      checks++;
      if (o0 !== {1'b1, lit}) begin
         errors++;
         $display("FAIL directed_hi: got %h want %h", o0, {1'b1, lit});
      end
      checks++;
      if (o1 !== {1'b1, lit}) begin
         errors++;
         $display("FAIL directed_reg: got %h want %h", o1, {1'b1, lit});
      end
   endtask

   task automatic test_loopback();
      vid_t prev;
      loop = 1'b1;
      @(negedge clk);
      pv = rand_vid();
      prev = pv;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         checks++;
         if (u1 !== prev) begin
            errors++;
            $display("FAIL loop_reg[%0d]: got %h want %h", n, u1, prev);
         end
         pv = rand_vid();
         #1;
         checks++;
         if (u0 !== pv) begin
            errors++;
            $display("FAIL loop_comb[%0d]: got %h want %h", n, u0, pv);
         end
         checks++;
         if (o0 !== exp_pack(clk, pv) || u0_clk !== clk || u1_clk !== clk) begin
            errors++;
            $display("FAIL loop_pack[%0d]: got %h want %h", n, o0, exp_pack(clk, pv));
         end
         prev = pv;
      end
      loop = 1'b0;
   endtask

   task automatic test_unpack_const();
      loop = 1'b0;
      drv = 49'h1_0000_0000_0000;
      #1;
      checks++;
      if (u0_clk !== 1'b1 || u0 !== vid_t'(0) || u1_clk !== 1'b1 || u1 !== vid_t'(0)) begin
         errors++;
         $display("FAIL unpack_clkonly: got %b %h want 1 0", u0_clk, u0);
      end
      drv = '1;
      #1;
      checks++;
      if (u0_x !== 11'd2047 || u0_y !== 10'd1023) begin
         errors++;
         $display("FAIL unpack_ones_xy: got %0d %0d want 2047 1023", u0_x, u0_y);
      end
      checks++;
      if (u1 !== vid_t'('1) || u0_r !== 8'hFF || u0_hs !== 1'b1 || u1_clk !== 1'b1) begin
         errors++;
         $display("FAIL unpack_ones: got %h want all ones", u1);
      end
   endtask

   task automatic test_reset_mid();
      vid_t dv;
      loop = 1'b0;
      dv = rand_vid();
      drv = {1'b1, 48'(dv)};
      pv = '1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (o1 !== {1'b0, 48'hFFFF_FFFF_FFFF}) begin
         errors++;
         $display("FAIL mid_before: got %h want %h", o1, {1'b0, 48'hFFFF_FFFF_FFFF});
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (o1 !== {1'b0, 48'h0}) begin
         errors++;
         $display("FAIL mid_async_clear: got %h want 0", o1);
      end
      checks++;
      if (o0 !== {1'b0, 48'hFFFF_FFFF_FFFF}) begin
         errors++;
         $display("FAIL mid_comb_unaffected: got %h", o0);
      end
      checks++;
      if (u0 !== dv || u1 !== dv || u1_clk !== 1'b1) begin
         errors++;
         $display("FAIL mid_unpack_unaffected: got %h want %h", u1, dv);
      end
      #1 rstn = 1'b1;
      #0.5;
      checks++;
      if (o1[47:0] !== 48'h0) begin
         errors++;
         $display("FAIL mid_hold_till_edge: got %h want 0", o1);
      end
      @(posedge clk);
      #1;
      checks++;
      if (o1 !== {1'b1, 48'hFFFF_FFFF_FFFF}) begin
         errors++;
         $display("FAIL mid_recapture: got %h want all ones", o1);
      end
   endtask

   task automatic test_frame_sweep();
      int lines [6] = '{0, 1, 360, 718, 719, 720};
      int de_in, de0, de1;
      vid_t prev, cur;
      de_in = 0;
      de0 = 0;
      de1 = 0;
      loop = 1'b1;
      @(negedge clk);
      pv = '0;
      prev = pv;
      for (int l = 0; l < 6; l++) begin
         for (int x = 0; x < 1300; x++) begin
            @(negedge clk);
            checks++;
            if ({u1.x, u1.y, u1.de} !== {prev.x, prev.y, prev.de}) begin
               errors++;
               $display("FAIL sweep_reg y=%0d x=%0d: got %0d %0d %b", lines[l], x, u1.x, u1.y, u1.de);
            end
            if (u1.de) de1++;
            cur = rand_vid();
            cur.x = XW'(x);
            cur.y = YW'(lines[l]);
            cur.de = (x < 1280) && (lines[l] < 720);
            cur.hs = (x >= 1290) && (x < 1295);
            cur.vs = (lines[l] >= 720);
            pv = cur;
            if (cur.de) de_in++;
            #1;
            checks++;
            if ({u0.x, u0.y, u0.de} !== {cur.x, cur.y, cur.de}) begin
               errors++;
               $display("FAIL sweep_comb y=%0d x=%0d: got %0d %0d %b", lines[l], x, u0.x, u0.y, u0.de);
            end
            if (u0.de) de0++;
            prev = cur;
         end
      end
      @(negedge clk);
      if (u1.de) de1++;
      checks++;
      if (de0 != de_in || de1 != de_in) begin
         errors++;
         $display("FAIL sweep_de_count: got %0d %0d want %0d", de0, de1, de_in);
      end
      loop = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_loopback();
      test_unpack_const();
      test_reset_mid();
      test_frame_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hdmi_pack_unpack.md
HDMI_PACK_UNPACK -- requirements
Module: hdmi_pack_unpack

Interface
REQ-001 Parameters SHALL be: H_ACT, default 1280, active pixels per line; V_ACT, default 720, active lines per frame; OUT_REG, default 0, where 1 registers the pack output.
REQ-002 Derived widths SHALL be XW = clog2(H_ACT) (11) and YW = clog2(V_ACT) (10), giving PACK_SIZE = 3*8 + 4 + XW + YW (49).
REQ-003 clk  input  1  single clock, also carried in the pack word.
REQ-004 rstn  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 p_hsync, p_vsync, p_de  input  1 each  pack-side sync and data-enable.
REQ-006 p_r, p_g, p_b  input  8 each  pack-side pixel colour.
REQ-007 p_x  input  XW  pack-side column; p_y  input  YW  pack-side row.
REQ-008 o_pack  output  PACK_SIZE  packed video bus.
REQ-009 i_pack  input  PACK_SIZE  packed bus to decode.
REQ-010 u_clk, u_hsync, u_vsync, u_de  output  1 each  decoded control bits.
REQ-011 u_r, u_g, u_b  output  8 each  decoded colour.
REQ-012 u_x  output  XW  decoded column; u_y  output  YW  decoded row.

Function
REQ-013 Pack layout, MSB to LSB, SHALL be: clk [48], hsync [47], vsync [46], de [45], r [44:37], g [36:29], b [28:21], x [20:10], y [9:0]; offsets track XW/YW for other parameters.
REQ-014 The unpack path SHALL be purely combinational: each u_* output equals its i_pack field with zero latency, with no dependence on clk or rstn.
REQ-015 With OUT_REG=0, o_pack SHALL be a purely combinational concatenation of the p_* inputs and clk.
REQ-016 With OUT_REG=1, all o_pack fields except the clk bit SHALL be registered on the rising edge of clk, giving 1-cycle latency.
REQ-017 The o_pack clk bit SHALL always be driven directly by clk and SHALL never be registered, in either mode.
REQ-018 Packing SHALL be lossless: x and y are truncated to XW/YW, no saturation is applied, and out-of-range values (e.g. x >= H_ACT) pass through unchanged.
REQ-019 unpack(pack(v)) SHALL equal v for every field, in both modes (after the latency in OUT_REG=1).
REQ-020 The block SHALL perform no interpretation of the timing: de/hsync/vsync combinations, including simultaneous assertion, pass through verbatim.

Reset
REQ-021 With OUT_REG=1, asserting rstn low SHALL immediately force every registered o_pack field to 0, while the clk bit stays live.
REQ-022 On rstn deassertion, registered fields SHALL capture inputs on the first following clk rising edge.
REQ-023 Assertion of rstn mid-frame SHALL zero o_pack data fields (de=0) at once and SHALL NOT affect the unpack path.
REQ-024 With OUT_REG=0, rstn SHALL have no functional effect.

Structure
REQ-025 A shared package hdmi_pkg SHALL hold H_ACT/V_ACT defaults, the XW/YW/PACK_SIZE functions and the field bit offsets.
REQ-026 The pack and unpack halves SHALL be implemented as separate instantiable sub-modules hdmi_pack and hdmi_unpack.
REQ-027 hdmi_pack_unpack SHALL be a thin wrapper around hdmi_pack and hdmi_unpack.
REQ-028 Consumers SHALL obtain the clock from the u_clk field of the pack bus.

Verification
REQ-029 OUT_REG=0, inputs hsync=1, vsync=0, de=1, r=8'hA5, g=8'h3C, b=8'h0F, x=1279, y=719 -> o_pack[47:0] equals 48'h_A5_3C_0F concatenated with {hsync,vsync,de}=3'b101, x=11'd1279 and y=10'd719 per REQ-013, and o_pack[48] tracks clk.
REQ-030 Loopback o_pack to i_pack with 1000 random vectors -> every u_* field equals the corresponding p_* input (OUT_REG=0 same cycle; OUT_REG=1 next cycle).
REQ-031 OUT_REG=1, hold inputs at all-ones, pulse rstn low between edges -> o_pack[47:0]=0 immediately; all-ones reappear at the first edge after release.
REQ-032 i_pack=49'h1_0000_0000_0000 -> u_clk=1 and all other outputs 0; i_pack all-ones -> u_x=2047 and u_y=1023 (no clamping).
REQ-033 Frame sweep 1280x720 with de high only in the active area -> decoded x/y/de sequence is identical to the driven one, with no dropped or extra de cycles.
